gaussian_stream: RTL

//  Streaming 3x3 binomial Gaussian filter ([1 2 1;2 4 2;1 2 1]/16) for raster-order images, CHANNELS lanes in parallel.

---
 rtl/gaussian_pkg.sv | 27 ++
 rtl/gaussian_line_buf.sv | 32 +++
 rtl/gaussian_stream.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/gaussian_pkg.sv
// Shared definitions for the streaming 3x3 binomial Gaussian filter.
//   - KW         : kernel weights [1 2 1; 2 4 2; 1 2 1] (sum 16)
//   - KSHIFT     : normalising right shift (divide by 16)
//   - ROUND_BIAS : half-LSB bias added before the shift when rounding is enabled
//   - state_t    : frame FSM states
//   - sum_width  : accumulator width needed for one channel (BITS+4)
package gaussian_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int KSHIFT     = 4;
    localparam int ROUND_BIAS = 8;

    // Row 0 = two lines above the incoming pixel, row 2 = incoming line.
    localparam int KW [3][3] = '{'{1, 2, 1}, '{2, 4, 2}, '{1, 2, 1}};

    // 16 * (2^bits - 1) needs exactly bits+4 bits, so no overflow is possible.
    function automatic int sum_width(input int bits);
        return bits + KSHIFT;
    endfunction

endpackage

// File: rtl/gaussian_line_buf.sv
// One-line delay buffer for the Gaussian window.
// Write is synchronous; read is combinational at the same address so the
// value stored one line ago is available in the cycle the new pixel arrives.
// Ports:
//   i_clk    : clock
//   i_we     : write enable (pixel accepted)
//   i_addr   : column address
//   i_wdata  : data written at i_addr
//   o_rdata  : current contents at i_addr (pre-write value)
// Contents are not cleared by reset.
module gaussian_line_buf #(
    parameter int DEPTH = 640,
    parameter int WIDTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_addr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule

// File: rtl/gaussian_stream.sv
// Streaming 3x3 binomial Gaussian filter, raster order, CHANNELS lanes.
// Emits interior pixels only: (IMG_W-2)*(IMG_H-2) outputs per frame.
// Optional build macro: GAUSSIAN_ROUND_EN -> result = (sum+8)>>4,
// otherwise result = sum>>4 (truncate).
// Ports:
//   i_clk        : clock
//   i_rst_n      : asynchronous active-low reset
//   i_start      : one-cycle frame start (honoured only in IDLE)
//   i_in_valid   : input pixel valid
//   o_in_ready   : input accepted when i_in_valid && o_in_ready
//   i_in_data    : input pixel, channels packed LSB-first
//   o_out_valid  : filtered pixel valid
//   i_out_ready  : sink accepts when o_out_valid && i_out_ready
//   o_out_data   : filtered pixel, channels packed LSB-first
//   o_busy       : high in RUN and DRAIN
//   o_done       : one-cycle pulse after the last output handshake
module gaussian_stream
    import gaussian_pkg::*;
#(
    parameter int BITS     = 8,
    parameter int CHANNELS = 1,
    parameter int IMG_W    = 640,
    parameter int IMG_H    = 480
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_start,
    input  logic                     i_in_valid,
    output logic                     o_in_ready,
    input  logic [CHANNELS*BITS-1:0] i_in_data,
    output logic                     o_out_valid,
    input  logic                     i_out_ready,
    output logic [CHANNELS*BITS-1:0] o_out_data,
    output logic                     o_busy,
    output logic                     o_done
);

    localparam int DW    = CHANNELS * BITS;
    localparam int SUM_W = sum_width(BITS);
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);

    state_t           r_state;
    state_t           w_state_next;
    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             r_out_valid;
    logic [DW-1:0]    r_out_data;

    // Two most recent window columns; the third is the column arriving now.
    logic [DW-1:0]    r_col_a [3];
    logic [DW-1:0]    r_col_b [3];
    logic [DW-1:0]    w_col_new [3];
    logic [DW-1:0]    w_win [3][3];

    logic [DW-1:0]    w_lb0_rd;
    logic [DW-1:0]    w_lb1_rd;
    logic [DW-1:0]    w_result;
    logic             w_in_ready;
    logic             w_accept;
    logic             w_col_last;
    logic             w_row_last;
    logic             w_qualify;

    assign w_in_ready = (r_state == RUN) && (!r_out_valid || i_out_ready);
    assign w_accept   = i_in_valid && w_in_ready;
    assign w_col_last = (r_col == COL_W'(IMG_W - 1));
    assign w_row_last = (r_row == ROW_W'(IMG_H - 1));
    // Only full windows inside the current line produce an output.
    assign w_qualify  = (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));

    // linebuf0 holds the previous line, linebuf1 the line before that.
    gaussian_line_buf #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb0 (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (i_in_data),
        .o_rdata (w_lb0_rd)
    );

    gaussian_line_buf #(.DEPTH(IMG_W), .WIDTH(DW)) u_lb1 (
        .i_clk   (i_clk),
        .i_we    (w_accept),
        .i_addr  (r_col),
        .i_wdata (w_lb0_rd),
        .o_rdata (w_lb1_rd)
    );

    always_comb begin
        w_col_new[0] = w_lb1_rd;
        w_col_new[1] = w_lb0_rd;
        w_col_new[2] = i_in_data;
        for (int r = 0; r < 3; r++) begin
            w_win[r][0] = r_col_a[r];
            w_win[r][1] = r_col_b[r];
            w_win[r][2] = w_col_new[r];
        end
    end

    // Per-channel kernel evaluated on the window as it will look after this accept.
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SUM_W-1:0] w_sum;
            logic [SUM_W-1:0] w_biased;

            always_comb begin
                w_sum = '0;
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) begin
                        w_sum = w_sum + SUM_W'(KW[r][c]) * SUM_W'(w_win[r][c][gi*BITS +: BITS]);
                    end
                end
            end

`ifdef GAUSSIAN_ROUND_EN
            assign w_biased = w_sum + SUM_W'(ROUND_BIAS);
`else
            assign w_biased = w_sum;
`endif
            assign w_result[gi*BITS +: BITS] = BITS'(w_biased >> KSHIFT);
        end
    endgenerate

    // Frame FSM: state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Frame FSM: next state and status outputs.
    always_comb begin
        w_state_next = r_state;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) w_state_next = RUN;
            end
            RUN: begin
                o_busy = 1'b1;
                if (w_accept && w_col_last && w_row_last) w_state_next = DRAIN;
            end
            DRAIN: begin
                o_busy = 1'b1;
                // Leave as the final output is taken so done follows that handshake directly.
                if (!r_out_valid || i_out_ready) w_state_next = DONE;
            end
            DONE: begin
                o_done       = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // Counters, window and output register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            for (int r = 0; r < 3; r++) begin
                r_col_a[r] <= '0;
                r_col_b[r] <= '0;
            end
        end else begin
            if (r_state == IDLE && i_start) begin
                r_col <= '0;
                r_row <= '0;
            end else if (w_accept) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + ROW_W'(1);
                end else begin
                    r_col <= r_col + COL_W'(1);
                end
            end

            if (w_accept) begin
                for (int r = 0; r < 3; r++) begin
                    r_col_a[r] <= r_col_b[r];
                    r_col_b[r] <= w_col_new[r];
                end
            end

            if (w_accept && w_qualify) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_result;
            end else if (i_out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign o_in_ready  = w_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_out_data  = r_out_data;

endmodule
